// File: rtl/lfsr_checker.sv
// lfsr_checker
//   Receive-side PRBS checker. Self-synchronises a local LFSR to an incoming
//   serial stream, then free-runs it and compares every received bit against
//   the local prediction.
//
//   State flow: HUNT (fill N bits) -> VERIFY (SYNC_COUNT consecutive correct
//   predictions) -> LOCKED (free-running compare with windowed loss detect).
//
// Ports
//   clk_i        clock, all logic on the rising edge
//   reset_i      synchronous, active-high reset
//   data_i       received serial bit
//   valid_i      data_i carries a new bit this cycle
//   clear_i      zero bit_count_o and err_count_o
//   locked_o     checker is in LOCKED
//   bit_err_o    one-cycle pulse: last locked bit mismatched
//   sync_loss_o  one-cycle pulse: lock dropped
//   bit_count_o  bits compared while locked (saturating)
//   err_count_o  mismatches while locked (saturating)
module lfsr_checker #(
    parameter int           N              = 8,
    parameter logic [N-1:0] TAPS           = 8'b00000011,
    parameter int           SYNC_COUNT     = 16,
    parameter int           WINDOW         = 64,
    parameter int           LOSS_THRESHOLD = 8,
    parameter int           CNT_WIDTH      = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 data_i,
    input  logic                 valid_i,
    input  logic                 clear_i,
    output logic                 locked_o,
    output logic                 bit_err_o,
    output logic                 sync_loss_o,
    output logic [CNT_WIDTH-1:0] bit_count_o,
    output logic [CNT_WIDTH-1:0] err_count_o
);
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int FILL_W  = $clog2(N + 1);
    localparam int MATCH_W = $clog2(SYNC_COUNT + 1);
    localparam int WBITS_W = $clog2(WINDOW + 1);
    localparam int WERRS_W = $clog2(LOSS_THRESHOLD + 1);

    // Transitions are decided on the pre-increment value, so compare
    // against "last" values rather than the terminal counts.
    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(N - 1);
    localparam logic [MATCH_W-1:0] MATCH_LAST = MATCH_W'(SYNC_COUNT - 1);
    localparam logic [WBITS_W-1:0] WBITS_LAST = WBITS_W'(WINDOW - 1);
    localparam logic [WERRS_W-1:0] WERRS_LAST = WERRS_W'(LOSS_THRESHOLD - 1);

    state_t                 state_q, state_d;
    logic [N-1:0]           r_q, r_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [MATCH_W-1:0]     match_q, match_d;
    logic [WBITS_W-1:0]     win_bits_q, win_bits_d;
    logic [WERRS_W-1:0]     win_errs_q, win_errs_d;
    logic [CNT_WIDTH-1:0]   bit_count_q, bit_count_d;
    logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
    logic                   locked_q, locked_d;
    logic                   bit_err_q, bit_err_d;
    logic                   sync_loss_q, sync_loss_d;

    // Prediction: XOR of the tapped state bits.
    logic [N-1:0] tap_bits;
    logic         pred;
    logic         mismatch;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_taps
            assign tap_bits[gi] = r_q[gi] & TAPS[gi];
        end
    endgenerate

    assign pred     = ^tap_bits;
    assign mismatch = data_i ^ pred;

    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_bits_d  = win_bits_q;
        win_errs_d  = win_errs_q;
        bit_count_d = bit_count_q;
        err_count_d = err_count_q;
        bit_err_d   = 1'b0;
        sync_loss_d = 1'b0;

        if (valid_i) begin
            unique case (state_q)
                HUNT: begin
                    r_d = {data_i, r_q[N-1:1]};
                    if (fill_q == FILL_LAST) begin
                        state_d = VERIFY;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                VERIFY: begin
                    // The received bit enters r even when it is wrong; the
                    // refill from HUNT flushes it out again.
                    r_d = {data_i, r_q[N-1:1]};
                    if (mismatch) begin
                        state_d = HUNT;
                        fill_d  = '0;
                    end else if (match_q == MATCH_LAST) begin
                        state_d    = LOCKED;
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        match_d = match_q + MATCH_W'(1);
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a channel error cannot
                    // propagate into later predictions.
                    r_d = {pred, r_q[N-1:1]};
                    if (bit_count_q != '1) begin
                        bit_count_d = bit_count_q + CNT_WIDTH'(1);
                    end
                    if (mismatch) begin
                        bit_err_d = 1'b1;
                        if (err_count_q != '1) begin
                            err_count_d = err_count_q + CNT_WIDTH'(1);
                        end
                    end
                    // Loss check wins over the window rollover on the same bit.
                    if (mismatch && (win_errs_q == WERRS_LAST)) begin
                        sync_loss_d = 1'b1;
                        state_d     = HUNT;
                        fill_d      = '0;
                    end else if (win_bits_q == WBITS_LAST) begin
                        win_bits_d = '0;
                        win_errs_d = '0;
                    end else begin
                        win_bits_d = win_bits_q + WBITS_W'(1);
                        if (mismatch) begin
                            win_errs_d = win_errs_q + WERRS_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = '0;
                end
            endcase
        end

        // Clear beats any increment in the same cycle.
        if (clear_i) begin
            bit_count_d = '0;
            err_count_d = '0;
        end

        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= HUNT;
            r_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_bits_q  <= '0;
            win_errs_q  <= '0;
            bit_count_q <= '0;
            err_count_q <= '0;
            locked_q    <= 1'b0;
            bit_err_q   <= 1'b0;
            sync_loss_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_errs_q  <= win_errs_d;
            bit_count_q <= bit_count_d;
            err_count_q <= err_count_d;
            locked_q    <= locked_d;
            bit_err_q   <= bit_err_d;
            sync_loss_q <= sync_loss_d;
        end
    end

    assign locked_o    = locked_q;
    assign bit_err_o   = bit_err_q;
    assign sync_loss_o = sync_loss_q;
    assign bit_count_o = bit_count_q;
    assign err_count_o = err_count_q;

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receive-side companion of the LFSR pattern generator. It consumes a serial PRBS bit stream with a valid qualifier and self-synchronises a local LFSR using the same polynomial and shift convention. Once locked, it compares every received bit against the local prediction and reports per-bit errors, error and bit counts, and loss of synchronisation. It sits at the far end of a link or loopback under test and is fed directly by the generator's data/valid pair or by the channel output.

## Interface
- N, 8, LFSR length in bits
- TAPS, 8'b00000011, feedback tap mask; must equal the generator's
- SYNC_COUNT, 16, consecutive correct predictions required to declare lock
- WINDOW, 64, length of the loss-of-sync observation window in locked bits
- LOSS_THRESHOLD, 8, errors within one window that force loss of sync
- CNT_WIDTH, 32, width of bit and error counters

- clk_i  in  1  clock, all logic on rising edge
- reset_i  in  1  synchronous, active-high reset
- data_i  in  1  received serial bit
- valid_i  in  1  data_i is a new bit this cycle
- clear_i  in  1  zero bit_count_o and err_count_o
- locked_o  out  1  checker is in LOCKED
- bit_err_o  out  1  one-cycle pulse: last locked bit mismatched
- sync_loss_o  out  1  one-cycle pulse: lock dropped
- bit_count_o  out  CNT_WIDTH  bits compared while locked, saturating
- err_count_o  out  CNT_WIDTH  mismatches while locked, saturating

## Operation
- State register r[N-1:0] follows the generator's convention: the stream bit order is r[0] first. Accepting bit b gives r <= {b, r[N-1:1]}. Prediction p = XOR over i of (r[i] & TAPS[i]).
- A bit is accepted only when valid_i=1. With valid_i=0, all state, counters and outputs hold, except that pulses deassert.
- HUNT (reset state): shift data_i into r and count fill bits. After N accepted bits, go to VERIFY with the match counter at 0.
- VERIFY: compare data_i with p and shift data_i into r.
  - Match: increment the match counter. When it reaches SYNC_COUNT, go to LOCKED and clear the window counters.
  - Mismatch: go to HUNT and restart the fill at 0. The bad bit still enters r.
  - Errors in VERIFY do not affect the counters or bit_err_o.
- LOCKED: r free-runs on the prediction (r <= {p, r[N-1:1]}). The received bit never enters r, so a single channel error produces exactly one error.
  - Each accepted bit increments bit_count_o.
  - On mismatch, increment err_count_o and the window error counter, and pulse bit_err_o.
  - The window bit counter counts accepted bits. After WINDOW bits, both window counters clear.
  - When the window error count reaches LOSS_THRESHOLD, including the bit that reaches it, pulse sync_loss_o and go to HUNT with the fill at 0. bit_count_o and err_count_o hold.
- Counters saturate at all-ones and never wrap.
- clear_i has priority over an increment in the same cycle, so the result is 0. clear_i does not affect state or lock.
- reset_i: state HUNT, r=0, all counters 0, all outputs 0. Reset takes priority over every other input.

## Timing
- All outputs are registered and update on the edge that accepts the bit, so they are visible the cycle after valid_i.
- Lock latency on a clean stream: locked_o is high the cycle after the (N+SYNC_COUNT)-th accepted bit. With defaults, that is bit 24.
- bit_err_o, and the count update, appear 1 cycle after the bad bit's valid cycle.
- sync_loss_o pulses in the same cycle that locked_o falls. The bit that triggered the loss also pulses bit_err_o and is counted.
- Throughput is 1 bit per clock when valid_i is held high. There is no back-pressure.

## Test plan
- Clean stream from the generator (START 0x01, TAPS 0x03; first bits 1,0,0,0,0,0,0,0,1,0,0,0,0,0,0,1,1), valid_i continuous -> locked_o rises after bit 24, then 100 more bits -> bit_count_o=100, err_count_o=0, bit_err_o never asserted.
- Locked, invert the 50th locked bit only -> exactly one bit_err_o pulse, err_count_o=1, locked_o stays 1, no further errors.
- Invert the 10th VERIFY bit (stream bit 18) -> back to HUNT, locked_o rises after bit 18+8+16=42.
- Locked, invert 8 bits within one 64-bit window -> sync_loss_o pulse on the 8th, locked_o=0, counters hold at 8 errors. A clean stream then resumes -> relock 24 valid bits later. The same 8 errors spread over two windows (4+4) -> lock retained.
- valid_i toggling randomly at 50% with data changing on invalid cycles -> lock at the 24th valid bit, and bit_count_o equals the number of valid locked bits. With CNT_WIDTH=4 and all bits inverted under LOSS_THRESHOLD=WINDOW=64 -> counters saturate at 15.
- clear_i asserted in the same cycle as a mismatching bit -> err_count_o=0 and bit_count_o=0 the next cycle, locked_o unchanged. reset_i pulsed while locked -> all outputs 0 the next cycle and hunt restarts.
